// File: rtl/fifo_test_pkg.sv
// Shared types and pattern helpers for the FIFO burst self-test.
package fifo_test_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StWait,
    StDrain,
    StDone
  } state_e;

  // Maximal-length Fibonacci tap masks, bit i set means stage i feeds the XOR.
  localparam logic [15:0] LfsrTaps4  = 16'h000C;
  localparam logic [15:0] LfsrTaps5  = 16'h0014;
  localparam logic [15:0] LfsrTaps6  = 16'h0030;
  localparam logic [15:0] LfsrTaps7  = 16'h0060;
  localparam logic [15:0] LfsrTaps8  = 16'h00B8;
  localparam logic [15:0] LfsrTaps9  = 16'h0110;
  localparam logic [15:0] LfsrTaps10 = 16'h0240;
  localparam logic [15:0] LfsrTaps11 = 16'h0500;
  localparam logic [15:0] LfsrTaps12 = 16'h0829;
  localparam logic [15:0] LfsrTaps13 = 16'h100D;
  localparam logic [15:0] LfsrTaps14 = 16'h2015;
  localparam logic [15:0] LfsrTaps15 = 16'h6000;
  localparam logic [15:0] LfsrTaps16 = 16'hD008;

  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    logic [15:0] taps;
    case (width)
      4:       taps = LfsrTaps4;
      5:       taps = LfsrTaps5;
      6:       taps = LfsrTaps6;
      7:       taps = LfsrTaps7;
      8:       taps = LfsrTaps8;
      9:       taps = LfsrTaps9;
      10:      taps = LfsrTaps10;
      11:      taps = LfsrTaps11;
      12:      taps = LfsrTaps12;
      13:      taps = LfsrTaps13;
      14:      taps = LfsrTaps14;
      15:      taps = LfsrTaps15;
      16:      taps = LfsrTaps16;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  // mode 0: increment; mode 1: left-shift LFSR with XOR feedback into the LSB.
  function automatic logic [15:0] next_pattern(input logic [15:0]   word,
                                               input logic          mode,
                                               input int unsigned   width);
    logic [31:0] mask;
    logic [15:0] nxt;
    mask = (32'd1 << width) - 32'd1;
    if (mode) begin
      nxt = {word[14:0], ^(word & lfsr_taps(width))};
    end else begin
      nxt = word + 16'd1;
    end
    return nxt & mask[15:0];
  endfunction

endpackage

// File: rtl/fifo_burst_tester_fifo.sv
// Single-clock FIFO with registered read data, registered full/empty and sticky error flags.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic [DATA_W-1:0]        i_din,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic [PTR_W:0]    w_count_next;
  logic [DATA_W-1:0] r_dout;
  logic              r_full;
  logic              r_empty;
  logic              r_ovf;
  logic              r_udf;
  logic              w_do_wr;
  logic              w_do_rd;

  assign w_do_wr = i_wr_en & ~r_full;
  assign w_do_rd = i_rd_en & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_do_wr, w_do_rd})
      2'b10:   w_count_next = r_count + (PTR_W + 1)'(1);
      2'b01:   w_count_next = r_count - (PTR_W + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      // A read from an empty FIFO leaves r_dout holding the previous word.
      if (w_do_rd) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_dout <= r_mem[r_rptr];
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == FullCnt);
      r_empty <= (w_count_next == '0);
      if (i_clr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        if (i_wr_en && r_full) r_ovf <= 1'b1;
        if (i_rd_en && r_empty) r_udf <= 1'b1;
      end
    end
  end

  assign o_dout  = r_dout;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;

endmodule

// File: rtl/fifo_burst_tester.sv
// Board self-test: SW0 edge writes a generated burst into a FIFO, waits, drains and checks it.
module fifo_burst_tester
  import fifo_test_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BURST_LEN = 16,
  parameter logic [15:0] SEED      = 16'h0095,
  parameter int unsigned PATTERN   = 0,
  parameter int unsigned READ_GAP  = 16,
  parameter int          FLIP_WORD = -1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW0,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic [7:0] err_cnt
);

  localparam int unsigned CNT_MAX = (BURST_LEN > READ_GAP) ? BURST_LEN : READ_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] BurstLast = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] BurstEnd  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] GapLast   = CNT_W'((READ_GAP == 0) ? 0 : READ_GAP - 1);
  localparam logic [DATA_W-1:0] SeedW    = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] SeedEff  = (PATTERN != 0 && SeedW == '0) ? DATA_W'(1) : SeedW;

  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] w);
    return DATA_W'(next_pattern(16'(w), PATTERN != 0, DATA_W));
  endfunction

  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_sync3;
  logic                   w_start;
  (* mark_debug = "true" *) state_e r_state;
  state_e                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  (* mark_debug = "true" *) logic w_wr_en;
  (* mark_debug = "true" *) logic w_rd_en;
  logic                   w_busy;
  logic                   w_fill_entry;
  logic                   w_drain_entry;
  logic                   w_done_entry;
  (* mark_debug = "true" *) logic [DATA_W-1:0] r_wr_pat;
  logic [DATA_W-1:0]      r_exp_pat;
  (* mark_debug = "true" *) logic [DATA_W-1:0] w_fifo_dout;
  logic [DATA_W-1:0]      w_chk_word;
  logic                   r_rd_vld;
  (* mark_debug = "true" *) logic [7:0] r_err_cnt;
  logic [7:0]             w_err_next;
  logic                   w_flip;
  logic                   w_mismatch;
  logic                   w_pass;
  logic                   r_pass;
  logic                   r_fail;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_ovf;
  logic                   w_udf;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= SW0;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_start = r_sync2 & ~r_sync3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (w_start) w_state_next = StFill;
      StFill:  if (r_cnt == BurstLast) w_state_next = (READ_GAP == 0) ? StDrain : StWait;
      StWait:  if (r_cnt == GapLast) w_state_next = StDrain;
      // Extra DRAIN cycle lets the last read word reach the comparator.
      StDrain: if (r_cnt == BurstEnd) w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
    w_cnt_next = (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
  end

  always_comb begin
    w_busy        = (r_state == StFill) || (r_state == StWait) || (r_state == StDrain);
    w_wr_en       = (r_state == StFill);
    w_rd_en       = (r_state == StDrain) && (r_cnt < BurstEnd);
    w_fill_entry  = (r_state != StFill) && (w_state_next == StFill);
    w_drain_entry = (r_state != StDrain) && (w_state_next == StDrain);
    w_done_entry  = (r_state != StDone) && (w_state_next == StDone);
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (w_fill_entry),
    .i_din   (r_wr_pat),
    .i_wr_en (w_wr_en),
    .i_rd_en (w_rd_en),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_ovf   (w_ovf),
    .o_udf   (w_udf)
  );

  // Debug hook: inverts bit 0 of the checked word at index FLIP_WORD; negative disables it.
  assign w_flip     = (FLIP_WORD >= 0) && (int'(r_cnt) == FLIP_WORD + 1);
  assign w_chk_word = w_fifo_dout ^ (w_flip ? DATA_W'(1) : '0);
  assign w_mismatch = r_rd_vld && (w_chk_word != r_exp_pat);
  assign w_err_next = (w_mismatch && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
  // Count and full cross-check empty so a corrupted occupancy also fails the run.
  assign w_pass     = (w_err_next == 8'd0) && w_empty && !w_full && (w_count == '0) &&
                      !w_ovf && !w_udf;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_pat  <= SeedEff;
      r_exp_pat <= SeedEff;
      r_rd_vld  <= 1'b0;
      r_err_cnt <= 8'd0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      if (w_fill_entry) begin
        r_wr_pat  <= SeedEff;
        r_err_cnt <= 8'd0;
        r_pass    <= 1'b0;
        r_fail    <= 1'b0;
      end else begin
        if (w_wr_en) r_wr_pat <= step(r_wr_pat);
        r_err_cnt <= w_err_next;
      end
      if (w_drain_entry) begin
        r_exp_pat <= SeedEff;
      end else if (r_rd_vld) begin
        r_exp_pat <= step(r_exp_pat);
      end
      r_rd_vld <= w_rd_en;
      if (w_done_entry) begin
        r_pass <= w_pass;
        r_fail <= !w_pass;
      end
    end
  end

  assign LED0    = r_sync2;
  assign LED1    = w_busy;
  assign LED2    = r_pass;
  assign LED3    = r_fail;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_fifo_burst_tester.sv
// Scoreboard bench for fifo_burst_tester: four configurations sharing one clock and reset.
module tb_fifo_burst_tester;
  import fifo_test_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sw = '0;
  wire [3:0][3:0] led;
  wire [3:0][7:0] err;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] q_wr[$];
  logic [7:0] q_rd[$];

  always #5 clk = ~clk;

  fifo_burst_tester dut_a (
    .CLK(clk), .RST(rst), .SW0(sw[0]), .LED0(led[0][0]), .LED1(led[0][1]),
    .LED2(led[0][2]), .LED3(led[0][3]), .err_cnt(err[0])
  );
  fifo_burst_tester #(.FLIP_WORD(5)) dut_b (
    .CLK(clk), .RST(rst), .SW0(sw[1]), .LED0(led[1][0]), .LED1(led[1][1]),
    .LED2(led[1][2]), .LED3(led[1][3]), .err_cnt(err[1])
  );
  fifo_burst_tester #(.PATTERN(1), .SEED(16'h0000)) dut_c (
    .CLK(clk), .RST(rst), .SW0(sw[2]), .LED0(led[2][0]), .LED1(led[2][1]),
    .LED2(led[2][2]), .LED3(led[2][3]), .err_cnt(err[2])
  );
  fifo_burst_tester #(.DEPTH(4), .BURST_LEN(4), .READ_GAP(0)) dut_d (
    .CLK(clk), .RST(rst), .SW0(sw[3]), .LED0(led[3][0]), .LED1(led[3][1]),
    .LED2(led[3][2]), .LED3(led[3][3]), .err_cnt(err[3])
  );

  // Reference generator, written independently for 8-bit words.
  function automatic logic [7:0] model_next(input logic [7:0] w, input bit lfsr);
    if (!lfsr) return w + 8'd1;
    return {w[6:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
  endfunction

  task automatic fill_queues(input logic [7:0] first, input bit lfsr, input int n);
    logic [7:0] w;
    w = first;
    q_wr.delete();
    q_rd.delete();
    for (int i = 0; i < n; i++) begin
      q_wr.push_back(w);
      q_rd.push_back(w);
      w = model_next(w, lfsr);
    end
  endtask

  task automatic wait_run(input int id, output int busy, output bit ok);
    int n;
    n = 0;
    busy = 0;
    while (n < 300 && led[id][1] !== 1'b1) begin @(negedge clk); n++; end
    while (n < 300 && led[id][1] === 1'b1) begin busy++; @(negedge clk); n++; end
    ok = (n < 300) && (led[id][2] === 1'b1 || led[id][3] === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (led[0] !== 4'h0) $display("FAIL reset_leds: got %b want 0000", led[0]);
    else n_pass++;
    n_chk++; if (err[0] !== 8'h00) $display("FAIL reset_err: got %h want 00", err[0]);
    else n_pass++;
    n_chk++; if (dut_a.r_state !== StIdle) $display("FAIL reset_state: got %0d want %0d",
                                                    dut_a.r_state, StIdle);
    else n_pass++;
    n_chk++; if (dut_a.w_count !== 5'd0) $display("FAIL reset_count: got %0d want 0",
                                                 dut_a.w_count);
    else n_pass++;
    n_chk++; if ({led[1], led[2], led[3]} !== 12'h000)
      $display("FAIL reset_leds_bcd: got %h want 000", {led[1], led[2], led[3]});
    else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (led[0] !== 4'h0) $display("FAIL post_reset_leds: got %b want 0000", led[0]);
    else n_pass++;
  endtask

  task automatic test_basic();
    int cyc, busy, last_wr, first_rd;
    bit done;
    logic [7:0] exp;
    cyc = 0; busy = 0; last_wr = -1; first_rd = -1; done = 0;
    fill_queues(8'h95, 1'b0, 16);
    sw[0] = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (led[0][1] === 1'b1) busy++;
      if (dut_a.w_wr_en === 1'b1) begin
        last_wr = cyc;
        n_chk++;
        if (q_wr.size() == 0) $display("FAIL basic_din: extra write %h", dut_a.r_wr_pat);
        else begin
          exp = q_wr.pop_front();
          if (dut_a.r_wr_pat !== exp) $display("FAIL basic_din: got %h want %h",
                                               dut_a.r_wr_pat, exp);
          else n_pass++;
        end
      end
      if (dut_a.w_rd_en === 1'b1 && first_rd < 0) first_rd = cyc;
      if (dut_a.r_rd_vld === 1'b1) begin
        n_chk++;
        if (q_rd.size() == 0) $display("FAIL basic_dout: extra read %h", dut_a.w_fifo_dout);
        else begin
          exp = q_rd.pop_front();
          if (dut_a.w_fifo_dout !== exp) $display("FAIL basic_dout: got %h want %h",
                                                  dut_a.w_fifo_dout, exp);
          else n_pass++;
        end
      end
      done = (led[0][2] === 1'b1) || (led[0][3] === 1'b1);
    end
    n_chk++; if (!done) $display("FAIL basic_timeout: got no DONE want DONE"); else n_pass++;
    n_chk++; if (q_wr.size() + q_rd.size() != 0)
      $display("FAIL basic_words_left: got %0d want 0", q_wr.size() + q_rd.size());
    else n_pass++;
    n_chk++; if (first_rd - last_wr != 17)
      $display("FAIL basic_gap: got %0d want 17", first_rd - last_wr);
    else n_pass++;
    n_chk++; if (busy != 49) $display("FAIL basic_latency: got %0d want 49", busy);
    else n_pass++;
    n_chk++; if (led[0] !== 4'b0101) $display("FAIL basic_leds: got %b want 0101", led[0]);
    else n_pass++;
    n_chk++; if (err[0] !== 8'h00) $display("FAIL basic_err: got %h want 00", err[0]);
    else n_pass++;
  endtask

  task automatic test_bitflip();
    int busy;
    bit ok;
    sw[1] = 1'b1;
    wait_run(1, busy, ok);
    n_chk++; if (!ok) $display("FAIL flip_timeout: got no DONE want DONE"); else n_pass++;
    n_chk++; if (err[1] !== 8'h01) $display("FAIL flip_err: got %h want 01", err[1]);
    else n_pass++;
    n_chk++; if (led[1][3:2] !== 2'b10) $display("FAIL flip_leds: got %b want 10", led[1][3:2]);
    else n_pass++;
  endtask

  task automatic test_lfsr();
    int cyc;
    bit done;
    logic [7:0] exp;
    cyc = 0; done = 0;
    fill_queues(8'h01, 1'b1, 16);
    sw[2] = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (dut_c.w_wr_en === 1'b1) begin
        n_chk++;
        if (q_wr.size() == 0) $display("FAIL lfsr_din: extra write %h", dut_c.r_wr_pat);
        else begin
          exp = q_wr.pop_front();
          if (dut_c.r_wr_pat !== exp) $display("FAIL lfsr_din: got %h want %h",
                                               dut_c.r_wr_pat, exp);
          else n_pass++;
        end
      end
      if (dut_c.r_rd_vld === 1'b1) begin
        n_chk++;
        if (q_rd.size() == 0) $display("FAIL lfsr_dout: extra read %h", dut_c.w_fifo_dout);
        else begin
          exp = q_rd.pop_front();
          if (dut_c.w_fifo_dout !== exp) $display("FAIL lfsr_dout: got %h want %h",
                                                  dut_c.w_fifo_dout, exp);
          else n_pass++;
        end
      end
      done = (led[2][2] === 1'b1) || (led[2][3] === 1'b1);
    end
    n_chk++; if (!done || q_wr.size() + q_rd.size() != 0)
      $display("FAIL lfsr_complete: got done=%0d left=%0d want done=1 left=0", done,
               q_wr.size() + q_rd.size());
    else n_pass++;
    n_chk++; if (led[2][3:2] !== 2'b01 || err[2] !== 8'h00)
      $display("FAIL lfsr_result: got leds=%b err=%h want 01 00", led[2][3:2], err[2]);
    else n_pass++;
  endtask

  task automatic test_full_nogap();
    int cyc, busy, nwr;
    bit done;
    cyc = 0; busy = 0; nwr = 0; done = 0;
    sw[3] = 1'b1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (led[3][1] === 1'b1) busy++;
      if (dut_d.w_wr_en === 1'b1) begin
        nwr++;
        if (nwr == 4) begin
          n_chk++; if (dut_d.w_full !== 1'b0) $display("FAIL nogap_full_early: got 1 want 0");
          else n_pass++;
          @(negedge clk);
          cyc++;
          if (led[3][1] === 1'b1) busy++;
          n_chk++; if (dut_d.w_full !== 1'b1)
            $display("FAIL nogap_full: got %b want 1", dut_d.w_full);
          else n_pass++;
          n_chk++; if (dut_d.w_rd_en !== 1'b1)
            $display("FAIL nogap_drain: got rd_en=%b want 1", dut_d.w_rd_en);
          else n_pass++;
        end
      end
      done = (led[3][2] === 1'b1) || (led[3][3] === 1'b1);
    end
    n_chk++; if (!done || busy != 9)
      $display("FAIL nogap_latency: got done=%0d busy=%0d want 1 9", done, busy);
    else n_pass++;
    n_chk++; if (led[3][3:2] !== 2'b01) $display("FAIL nogap_leds: got %b want 01",
                                                 led[3][3:2]);
    else n_pass++;
    n_chk++; if ({dut_d.w_empty, dut_d.w_ovf, dut_d.w_udf} !== 3'b100)
      $display("FAIL nogap_flags: got %b want 100",
               {dut_d.w_empty, dut_d.w_ovf, dut_d.w_udf});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, busy;
    bit ok;
    sw[0] = 1'b0;
    repeat (4) @(negedge clk);
    sw[0] = 1'b1;
    n = 0;
    while (n < 200 && !(dut_a.r_state == StDrain && dut_a.r_cnt == 2)) begin
      @(negedge clk);
      n++;
    end
    n_chk++; if (n >= 200) $display("FAIL mid_reach_drain: got timeout want DRAIN word 3");
    else n_pass++;
    rst = 1'b1;
    sw = '0;
    @(negedge clk);
    n_chk++; if (led[0] !== 4'h0) $display("FAIL mid_leds: got %b want 0000", led[0]);
    else n_pass++;
    n_chk++; if (dut_a.r_state !== StIdle || dut_a.w_empty !== 1'b1)
      $display("FAIL mid_idle_empty: got state=%0d empty=%b want 0 1",
               dut_a.r_state, dut_a.w_empty);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    sw[0] = 1'b1;
    wait_run(0, busy, ok);
    n_chk++; if (!ok || led[0][3:2] !== 2'b01 || err[0] !== 8'h00)
      $display("FAIL mid_rerun: got ok=%0d leds=%b err=%h want 1 01 00",
               ok, led[0][3:2], err[0]);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    int busy, rises, n;
    bit prev, ok;
    sw[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (led[0][0] !== 1'b0) $display("FAIL retrig_led0: got 1 want 0"); else n_pass++;
    sw[0] = 1'b1;
    busy = 0; rises = 0; prev = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (led[0][1] === 1'b1) begin
        busy++;
        if (!prev) rises++;
      end
      prev = (led[0][1] === 1'b1);
      if (i == 3) sw[0] = 1'b0;
      if (i == 6) sw[0] = 1'b1;
    end
    n_chk++; if (rises != 1 || busy != 49)
      $display("FAIL retrig_ignored: got runs=%0d busy=%0d want 1 49", rises, busy);
    else n_pass++;
    n_chk++; if (led[0][3:2] !== 2'b01) $display("FAIL retrig_pass: got %b want 01",
                                                 led[0][3:2]);
    else n_pass++;
    // Restart from DONE on a run that ends with one error, then confirm the count clears.
    sw[1] = 1'b1;
    wait_run(1, busy, ok);
    n_chk++; if (!ok || err[1] !== 8'h01)
      $display("FAIL retrig_first: got ok=%0d err=%h want 1 01", ok, err[1]);
    else n_pass++;
    sw[1] = 1'b0;
    repeat (4) @(negedge clk);
    sw[1] = 1'b1;
    n = 0;
    while (n < 20 && led[1][1] !== 1'b1) begin @(negedge clk); n++; end
    n_chk++; if (led[1][1] !== 1'b1 || err[1] !== 8'h00 || led[1][3:2] !== 2'b00)
      $display("FAIL retrig_clear: got busy=%b err=%h leds=%b want 1 00 00",
               led[1][1], err[1], led[1][3:2]);
    else n_pass++;
    wait_run(1, busy, ok);
    n_chk++; if (!ok || err[1] !== 8'h01)
      $display("FAIL retrig_second: got ok=%0d err=%h want 1 01", ok, err[1]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bitflip();
    test_lfsr();
    test_full_nogap();
    test_reset_mid();
    test_retrigger();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
